// File: rtl/cronometro_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cronometro_ctrl
// Brief    : Key synchroniser/debouncer and start/stop/clear FSM driving the
//            chronometer. Optional lap-hold key enabled by macro LAP_HOLD_EN.
// Revision : 1.0  initial release
// ============================================================================
module cronometro_ctrl #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int SYNC_STAGES     = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_ss_n,
   input  logic       key_clr_n,
`ifdef LAP_HOLD_EN
   input  logic       key_lap_n,
   output logic       lap_hold,
`endif
   output logic       start,
   output logic       clr,
   output logic [1:0] state
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

   // Key index map: 0 = start/stop, 1 = clear, 2 = lap (optional)
`ifdef LAP_HOLD_EN
   localparam int N_KEYS = 3;
`else
   localparam int N_KEYS = 2;
`endif

   logic [N_KEYS-1:0] w_keys_n;
   logic [N_KEYS-1:0] w_press;

`ifdef LAP_HOLD_EN
   assign w_keys_n = {key_lap_n, key_clr_n, key_ss_n};
`else
   assign w_keys_n = {key_clr_n, key_ss_n};
`endif

   genvar k;
   generate
      for (k = 0; k < N_KEYS; k++) begin : g_key
         logic [SYNC_STAGES-1:0] r_sync;
         logic [CNT_W-1:0]       r_cnt;
         logic                   r_deb;
         logic                   r_deb_d;
         logic                   r_press;
         logic                   w_s;

         assign w_s        = r_sync[SYNC_STAGES-1];
         assign w_press[k] = r_press;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_sync  <= '1;
               r_cnt   <= '0;
               r_deb   <= 1'b1;
               r_deb_d <= 1'b1;
               r_press <= 1'b0;
            end else begin
               r_sync  <= {r_sync[SYNC_STAGES-2:0], w_keys_n[k]};
               r_deb_d <= r_deb;
               r_press <= r_deb_d & ~r_deb;
               // Any sample matching the accepted level restarts the count.
               if (w_s == r_deb) begin
                  r_cnt <= '0;
               end else if (r_cnt == C_CNT_LAST) begin
                  r_deb <= w_s;
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + C_CNT_ONE;
               end
            end
         end
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10
   } state_t;

   state_t r_state;
   state_t w_state_nx;
   logic   r_start;
   logic   r_clr;
   logic   w_start_nx;
   logic   w_clr_nx;
   logic   w_ss_press;
   logic   w_clr_press;

   assign w_ss_press  = w_press[0];
   assign w_clr_press = w_press[1];

`ifdef LAP_HOLD_EN
   logic r_lap;
   logic w_lap_nx;
   logic w_lap_press;
   assign w_lap_press = w_press[2];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_start <= 1'b0;
         r_clr   <= 1'b0;
`ifdef LAP_HOLD_EN
         r_lap   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nx;
         r_start <= w_start_nx;
         r_clr   <= w_clr_nx;
`ifdef LAP_HOLD_EN
         r_lap   <= w_lap_nx;
`endif
      end
   end

   // Clear has priority over start/stop except in RUN, where clear is ignored.
   always_comb begin
      w_state_nx = r_state;
      w_clr_nx   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_clr_press) begin
               w_clr_nx = 1'b1;
            end else if (w_ss_press) begin
               w_state_nx = ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_ss_press) begin
               w_state_nx = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (w_clr_press) begin
               w_state_nx = ST_IDLE;
               w_clr_nx   = 1'b1;
            end else if (w_ss_press) begin
               w_state_nx = ST_RUN;
            end
         end
         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase
      w_start_nx = (w_state_nx == ST_RUN);
   end

`ifdef LAP_HOLD_EN
   always_comb begin
      w_lap_nx = r_lap;
      if (w_clr_nx) begin
         w_lap_nx = 1'b0;
      end else if ((r_state == ST_RUN) && w_lap_press) begin
         w_lap_nx = ~r_lap;
      end
   end

   assign lap_hold = r_lap;
`endif

   assign start = r_start;
   assign clr   = r_clr;
   assign state = r_state;

endmodule
`default_nettype wire
